// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: DDS tuning-word sequencer with manual/sweep/hold modes, debounced
// front-panel buttons and a registered waveform-select output mux.
module dds_sweep_ctrl #(
  parameter int TW_W    = 8,
  parameter int DWELL_W = 16,
  parameter int DEB_CNT = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_tick,
  input  logic               btn_mode,
  input  logic               btn_wave,
  input  logic [TW_W-1:0]    manual_tw,
  input  logic [TW_W-1:0]    tw_lo,
  input  logic [TW_W-1:0]    tw_hi,
  input  logic [TW_W-1:0]    step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [TW_W-1:0]    data_sin,
  input  logic [TW_W-1:0]    data_squ,
  input  logic [TW_W-1:0]    data_tri,
  input  logic [TW_W-1:0]    data_saw,
  output logic [TW_W-1:0]    tw_out,
  output logic [1:0]         wave_sel,
  output logic [1:0]         mode,
  output logic [TW_W-1:0]    wave_out,
  output logic               sweep_wrap,
  output logic               cfg_err
);
  localparam int CW = $clog2(DEB_CNT + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CNT - 1);
  typedef enum logic [1:0] {MANUAL, SWEEP_UP, SWEEP_TRI, HOLD} mode_t;
  logic [1:0]         btn, s1_q, s2_q, acc_q, press_q;
  logic [CW-1:0]      cnt_q [2];
  mode_t              mode_q, mode_d;
  logic [TW_W-1:0]    tw_q, wave_q, sample;
  logic [1:0]         wsel_q;
  logic               dir_q, wrap_q, err_q, in_sweep, to_sweep, bad;
  logic [DWELL_W-1:0] dwell_cnt_q, dw_last;
  logic [TW_W:0]      up_sum, lo_sum;
  assign btn = {btn_wave, btn_mode};
  // Bit 0 is the mode button, bit 1 the wave button; the counter restarts whenever
  // the synchronised level is about to change, so only a level held DEB_CNT cycles is accepted.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      acc_q   <= '0;
      press_q <= '0;
      cnt_q   <= '{default: '0};
    end else begin
      s1_q <= btn;
      s2_q <= s1_q;
      for (int b = 0; b < 2; b++) begin
        cnt_q[b]   <= (s1_q[b] != s2_q[b]) ? '0 : (cnt_q[b] == DEB_LAST) ? cnt_q[b] : cnt_q[b] + 1'b1;
        acc_q[b]   <= (s1_q[b] == s2_q[b] && cnt_q[b] == DEB_LAST) ? s2_q[b] : acc_q[b];
        press_q[b] <= s1_q[b] == s2_q[b] && cnt_q[b] == DEB_LAST && s2_q[b] && !acc_q[b];
      end
    end
  assign mode_d   = press_q[0] ? mode_t'(mode_q + 2'd1) : mode_q;
  assign in_sweep = mode_q == SWEEP_UP || mode_q == SWEEP_TRI;
  assign to_sweep = mode_d == SWEEP_UP || mode_d == SWEEP_TRI;
  assign bad      = tw_lo > tw_hi;
  assign dw_last  = (dwell == '0) ? '0 : dwell - 1'b1;
  assign up_sum   = {1'b0, tw_q} + {1'b0, step};
  assign lo_sum   = {1'b0, tw_lo} + {1'b0, step};
  assign sample   = wsel_q[1] ? (wsel_q[0] ? data_saw : data_tri) : (wsel_q[0] ? data_squ : data_sin);
  // A mode press pre-empts any step evaluated in the same cycle.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mode_q      <= MANUAL;
      tw_q        <= '0;
      wsel_q      <= '0;
      wave_q      <= '0;
      dir_q       <= 1'b0;
      dwell_cnt_q <= '0;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mode_q <= mode_d;
      wsel_q <= wsel_q + {1'b0, press_q[1]};
      wave_q <= sample;
      err_q  <= to_sweep && bad;
      wrap_q <= 1'b0;
      if (press_q[0]) begin
        if (to_sweep) begin
          tw_q        <= tw_lo;
          dir_q       <= 1'b0;
          dwell_cnt_q <= '0;
        end
      end else if (mode_q == MANUAL) begin
        tw_q <= manual_tw;
      end else if (in_sweep && bad) begin
        tw_q        <= tw_lo;
        dwell_cnt_q <= '0;
      end else if (in_sweep && sample_tick) begin
        if (dwell_cnt_q < dw_last) begin
          dwell_cnt_q <= dwell_cnt_q + 1'b1;
        end else begin
          dwell_cnt_q <= '0;
          if (step != '0) begin
            if (mode_q == SWEEP_UP) begin
              if (up_sum > {1'b0, tw_hi}) begin
                tw_q   <= tw_lo;
                wrap_q <= 1'b1;
              end else tw_q <= up_sum[TW_W-1:0];
            end else if (!dir_q) begin
              if (up_sum >= {1'b0, tw_hi}) begin
                tw_q  <= tw_hi;
                dir_q <= 1'b1;
              end else tw_q <= up_sum[TW_W-1:0];
            end else if ({1'b0, tw_q} < lo_sum) begin
              tw_q   <= tw_lo;
              dir_q  <= 1'b0;
              wrap_q <= 1'b1;
            end else tw_q <= tw_q - step;
          end
        end
      end
    end
  assign tw_out     = tw_q;
  assign wave_sel   = wsel_q;
  assign mode       = mode_q;
  assign wave_out   = wave_q;
  assign sweep_wrap = wrap_q;
  assign cfg_err    = err_q;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: randomized and directed bench for dds_sweep_ctrl against an
// integer reference model of the sweep rules.
module tb_dds_sweep_ctrl;
  localparam int DEB = 20;
  logic        clk = 0, rst = 0, sample_tick = 0, btn_mode = 0, btn_wave = 0;
  logic [7:0]  manual_tw = 0, tw_lo = 0, tw_hi = 0, step = 0;
  logic [7:0]  data_sin = 0, data_squ = 0, data_tri = 0, data_saw = 0;
  logic [15:0] dwell = 0;
  logic [7:0]  tw_out, wave_out;
  logic [1:0]  wave_sel, mode;
  logic        sweep_wrap, cfg_err;
  int n_run = 0, n_fail = 0;
  int m_mode = 0, m_wsel = 0, m_tw = 0, m_dir = 0, m_cnt = 0, m_wrap = 0;
  int up_seq [8] = '{10, 20, 20, 30, 30, 40, 40, 10};
  int tri_seq [7] = '{10, 20, 25, 15, 5, 0, 10};

  dds_sweep_ctrl #(.TW_W(8), .DWELL_W(16), .DEB_CNT(DEB)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .btn_mode(btn_mode), .btn_wave(btn_wave),
    .manual_tw(manual_tw), .tw_lo(tw_lo), .tw_hi(tw_hi), .step(step), .dwell(dwell),
    .data_sin(data_sin), .data_squ(data_squ), .data_tri(data_tri), .data_saw(data_saw),
    .tw_out(tw_out), .wave_sel(wave_sel), .mode(mode), .wave_out(wave_out),
    .sweep_wrap(sweep_wrap), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pick(input int w);
    return w == 0 ? data_sin : w == 1 ? data_squ : w == 2 ? data_tri : data_saw;
  endfunction

  function automatic int m_err();
    return ((m_mode == 1 || m_mode == 2) && tw_lo > tw_hi) ? 1 : 0;
  endfunction

  // Reference: count sample ticks, every max(dwell,1)-th tick apply one sweep step.
  task automatic model_step();
    int lo, hi, st, d;
    bit sw;
    lo = tw_lo; hi = tw_hi; st = step; d = (dwell == 0) ? 1 : dwell;
    sw = m_mode == 1 || m_mode == 2;
    m_wrap = 0;
    if (m_mode == 0) m_tw = manual_tw;
    else if (sw && lo > hi) begin
      m_tw = lo;
      m_cnt = 0;
    end else if (sw && sample_tick) begin
      m_cnt++;
      if (m_cnt >= d) begin
        m_cnt = 0;
        if (st > 0) begin
          if (m_mode == 1) begin
            if (m_tw + st > hi) begin m_tw = lo; m_wrap = 1; end
            else m_tw = m_tw + st;
          end else if (m_dir == 0) begin
            if (m_tw + st >= hi) begin m_tw = hi; m_dir = 1; end
            else m_tw = m_tw + st;
          end else if (m_tw < lo + st) begin
            m_tw = lo; m_dir = 0; m_wrap = 1;
          end else m_tw = m_tw - st;
        end
      end
    end
  endtask

  task automatic cycle(input int pct);
    logic [7:0] exp_wave;
    sample_tick = ($urandom_range(99) < pct);
    data_sin = 8'($urandom);
    data_squ = 8'($urandom);
    data_tri = 8'($urandom);
    data_saw = 8'($urandom);
    exp_wave = pick(m_wsel);
    tk();
    model_step();
    check("tw_out", tw_out, m_tw);
    check("sweep_wrap", sweep_wrap, m_wrap);
    check("cfg_err", cfg_err, m_err());
    check("mode", mode, m_mode);
    check("wave_sel", wave_sel, m_wsel);
    check("wave_out", wave_out, exp_wave);
  endtask

  // Bouncy press: 5 short toggles ending high, wait for the accepted press, then release.
  task automatic press(input bit is_mode);
    int waited;
    int prev;
    sample_tick = 0;
    prev = is_mode ? m_mode : m_wsel;
    for (int i = 0; i < 5; i++) begin
      if (is_mode) btn_mode = ~btn_mode;
      else btn_wave = ~btn_wave;
      repeat ($urandom_range(DEB / 2, 1)) tk();
    end
    waited = 0;
    while ((is_mode ? int'(mode) : int'(wave_sel)) == prev && waited < 4 * DEB) begin
      tk();
      waited++;
    end
    check("press_latency", waited < 4 * DEB, 1);
    if (is_mode) begin
      m_mode = (m_mode + 1) % 4;
      if (m_mode == 1 || m_mode == 2) begin
        m_tw = tw_lo; m_dir = 0; m_cnt = 0;
      end
      check("press_mode", mode, m_mode);
      check("press_tw", tw_out, m_tw);
      check("press_err", cfg_err, m_err());
    end else begin
      m_wsel = (m_wsel + 1) % 4;
      check("press_wave", wave_sel, m_wsel);
    end
    btn_mode = 0;
    btn_wave = 0;
    repeat (DEB + 8) tk();
    check("single_mode", mode, m_mode);
    check("single_wave", wave_sel, m_wsel);
  endtask

  task automatic rand_params();
    int r;
    r = $urandom_range(9);
    tw_lo = 8'($urandom_range(200));
    tw_hi = (r < 2) ? 8'($urandom_range(int'(tw_lo))) : (r < 4) ? tw_lo : 8'($urandom_range(255, int'(tw_lo)));
    step = ($urandom_range(6) == 0) ? 8'd0 : 8'($urandom_range(60, 1));
    dwell = 16'($urandom_range(3));
  endtask

  initial begin
    manual_tw = 8'h2A;
    repeat (3) tk();
    check("rst_tw", tw_out, 0);
    check("rst_wsel", wave_sel, 0);
    check("rst_mode", mode, 0);
    check("rst_wave", wave_out, 0);
    check("rst_wrap", sweep_wrap, 0);
    check("rst_err", cfg_err, 0);
    rst = 1;
    cycle(0);
    check("manual_2a", tw_out, 8'h2A);
    repeat (3) cycle(50);
    // sawtooth: 10,20,30,40 then wrap back to 10
    tw_lo = 10; tw_hi = 40; step = 10; dwell = 2;
    press(1);
    check("up_enter", tw_out, 10);
    for (int i = 0; i < 8; i++) begin
      cycle(100);
      check("up_seq", tw_out, up_seq[i]);
      check("up_wrap", sweep_wrap, i == 7);
    end
    // triangle: 0,10,20,25,15,5,0,10 with wrap at 5->0
    tw_lo = 0; tw_hi = 25; step = 10; dwell = 1;
    press(1);
    check("tri_enter", tw_out, 0);
    for (int i = 0; i < 7; i++) begin
      cycle(100);
      check("tri_seq", tw_out, tri_seq[i]);
      check("tri_wrap", sweep_wrap, i == 5);
    end
    press(1);
    repeat (6) cycle(100);
    check("hold_tw", tw_out, 10);
    press(1);
    repeat (3) cycle(50);
    for (int i = 0; i < 4; i++) begin
      press(0);
      repeat (3) cycle(50);
    end
    check("wave_back_to_sin", wave_sel, 0);
    // inverted bounds
    tw_lo = 50; tw_hi = 20; step = 5; dwell = 1;
    press(1);
    repeat (5) cycle(100);
    check("err_flag", cfg_err, 1);
    check("err_tw", tw_out, 50);
    press(1);
    press(1);
    check("hold_err", cfg_err, 0);
    check("hold_err_tw", tw_out, 50);
    repeat (3) cycle(100);
    press(1);
    for (int r = 0; r < 6; r++) begin
      manual_tw = 8'($urandom);
      rand_params();
      repeat (4) cycle(50);
      press(1);
      repeat (20) cycle(70);
      if ($urandom_range(1)) begin
        tw_hi = 8'($urandom_range(255, int'(tw_lo)));
        step = 8'($urandom_range(40));
      end
      repeat (20) cycle(70);
      if ($urandom_range(1)) press(0);
      rand_params();
      press(1);
      repeat (40) cycle(80);
      press(1);
      repeat (8) cycle(80);
      press(1);
      repeat (3) cycle(50);
    end
    // asynchronous reset in the middle of a sweep
    tw_lo = 5; tw_hi = 200; step = 7; dwell = 1;
    press(1);
    repeat (7) cycle(100);
    @(posedge clk);
    #3 rst = 0;
    #1;
    check("arst_tw", tw_out, 0);
    check("arst_mode", mode, 0);
    check("arst_wsel", wave_sel, 0);
    check("arst_wave", wave_out, 0);
    check("arst_wrap", sweep_wrap, 0);
    check("arst_err", cfg_err, 0);
    m_mode = 0; m_wsel = 0; m_tw = 0; m_dir = 0; m_cnt = 0;
    tk();
    rst = 1;
    repeat (3) cycle(50);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
